// File: rtl/vend_seq_ctrl.sv
// Vending sequencer: accepts 1/2-unit coins, dispenses on select, pays change or refunds.
// Every output is registered; the next-state logic is a single combinational block.
module vend_seq_ctrl #(
  parameter int PRICE       = 3,
  parameter int MAX_CREDIT  = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic       sel,
  input  logic       cancel,
  input  logic       disp_ack,
  input  logic       chg_ack,
  output logic       disp_req,
  output logic       chg_req,
  output logic [3:0] chg_amt,
  output logic [3:0] credit,
  output logic       coin_reject,
  output logic       busy,
  output logic [7:0] vend_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CREDIT   = 2'd1;
  localparam logic [1:0] S_DISPENSE = 2'd2;
  localparam logic [1:0] S_CHANGE   = 2'd3;

  logic [1:0]  r_state,       w_state_nxt;
  logic [3:0]  r_credit,      w_credit_nxt;
  logic [3:0]  r_chg_amt,     w_chg_amt_nxt;
  logic [15:0] r_timer,       w_timer_nxt;
  logic [7:0]  r_vend_cnt,    w_vend_cnt_nxt;
  logic        r_disp_req,    w_disp_req_nxt;
  logic        r_chg_req,     w_chg_req_nxt;
  logic        r_coin_reject, w_coin_reject_nxt;
  logic        r_busy,        w_busy_nxt;

  logic [1:0]  w_coin_val;
  logic [4:0]  w_sum;
  logic        w_accept;
  logic [3:0]  w_credit_acc;
  logic [15:0] w_timer_inc;
  logic [3:0]  w_remain;

  assign w_coin_val   = (coin == 2'b01) ? 2'd1 : ((coin == 2'b10) ? 2'd2 : 2'd0);
  assign w_sum        = {1'b0, r_credit} + {3'b000, w_coin_val};
  assign w_accept     = ((r_state == S_IDLE) || (r_state == S_CREDIT)) &&
                        (w_coin_val != 2'd0) && (w_sum <= 5'(MAX_CREDIT));
  assign w_credit_acc = w_accept ? w_sum[3:0] : r_credit;
  assign w_timer_inc  = r_timer + 16'd1;
  assign w_remain     = r_credit - 4'(PRICE);

  always_comb begin
    w_state_nxt       = r_state;
    w_credit_nxt      = r_credit;
    w_chg_amt_nxt     = r_chg_amt;
    w_timer_nxt       = r_timer;
    w_vend_cnt_nxt    = r_vend_cnt;
    w_disp_req_nxt    = r_disp_req;
    w_chg_req_nxt     = r_chg_req;
    // Any real coin that is not taken is bounced, whatever the state.
    w_coin_reject_nxt = (w_coin_val != 2'd0) && !w_accept;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = S_CREDIT;
          w_credit_nxt = w_credit_acc;
          w_timer_nxt  = 16'd0;
        end
      end
      S_CREDIT: begin
        w_credit_nxt = w_credit_acc;
        if (cancel) begin
          w_state_nxt   = S_CHANGE;
          w_chg_req_nxt = 1'b1;
          w_chg_amt_nxt = w_credit_acc;
          w_timer_nxt   = 16'd0;
        end else if (sel && (r_credit >= 4'(PRICE))) begin
          w_state_nxt    = S_DISPENSE;
          w_disp_req_nxt = 1'b1;
          w_timer_nxt    = 16'd0;
        end else if (w_accept || sel) begin
          w_timer_nxt = 16'd0;
        end else if (w_timer_inc == 16'(TIMEOUT_CYC)) begin
          w_state_nxt   = S_CHANGE;
          w_chg_req_nxt = 1'b1;
          w_chg_amt_nxt = r_credit;
          w_timer_nxt   = 16'd0;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      S_DISPENSE: begin
        if (disp_ack) begin
          w_disp_req_nxt = 1'b0;
          w_vend_cnt_nxt = r_vend_cnt + 8'd1;
          w_credit_nxt   = w_remain;
          if (w_remain == 4'd0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt   = S_CHANGE;
            w_chg_req_nxt = 1'b1;
            w_chg_amt_nxt = w_remain;
          end
        end
      end
      default: begin
        if (chg_ack) begin
          w_state_nxt   = S_IDLE;
          w_chg_req_nxt = 1'b0;
          w_chg_amt_nxt = 4'd0;
          w_credit_nxt  = 4'd0;
        end
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_credit      <= 4'd0;
      r_chg_amt     <= 4'd0;
      r_timer       <= 16'd0;
      r_vend_cnt    <= 8'd0;
      r_disp_req    <= 1'b0;
      r_chg_req     <= 1'b0;
      r_coin_reject <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_chg_amt     <= w_chg_amt_nxt;
      r_timer       <= w_timer_nxt;
      r_vend_cnt    <= w_vend_cnt_nxt;
      r_disp_req    <= w_disp_req_nxt;
      r_chg_req     <= w_chg_req_nxt;
      r_coin_reject <= w_coin_reject_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign disp_req    = r_disp_req;
  assign chg_req     = r_chg_req;
  assign chg_amt     = r_chg_amt;
  assign credit      = r_credit;
  assign coin_reject = r_coin_reject;
  assign busy        = r_busy;
  assign vend_cnt    = r_vend_cnt;

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Directed vector bench for vend_seq_ctrl (PRICE 3, MAX_CREDIT 6, TIMEOUT_CYC 20).
module tb_vend_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel, cancel, disp_ack, chg_ack;
  logic       disp_req, chg_req, coin_reject, busy;
  logic [3:0] chg_amt, credit;
  logic [7:0] vend_cnt;

  always #5 clk = ~clk;

  vend_seq_ctrl #(.PRICE(3), .MAX_CREDIT(6), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel),
    .disp_ack(disp_ack), .chg_ack(chg_ack), .disp_req(disp_req),
    .chg_req(chg_req), .chg_amt(chg_amt), .credit(credit),
    .coin_reject(coin_reject), .busy(busy), .vend_cnt(vend_cnt)
  );

  // Expected outputs packed as {disp_req, chg_req, chg_amt, credit, coin_reject, busy, vend_cnt}.
  typedef struct {
    logic        rst;
    logic [1:0]  coin;
    logic        sel, cancel, dack, cack;
    logic [19:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic s, cn, da, ca,
                              input logic d, ch, input logic [3:0] amt, cr,
                              input logic rj, bz, input logic [7:0] vc);
    vec_t v;
    v.rst = r; v.coin = c; v.sel = s; v.cancel = cn; v.dack = da; v.cack = ca;
    v.exp = {d, ch, amt, cr, rj, bz, vc};
    return v;
  endfunction

  task automatic step(input vec_t v, input string tag);
    logic [19:0] act;
    rst = v.rst; coin = v.coin; sel = v.sel; cancel = v.cancel;
    disp_ack = v.dack; chg_ack = v.cack;
    @(posedge clk);
    #1;
    act = {disp_req, chg_req, chg_amt, credit, coin_reject, busy, vend_cnt};
    n_checks++;
    if (act === v.exp) begin
      n_pass++;
      $display("%s: ok outputs=%05h", tag, act);
    end else begin
      $display("FAIL %s: got d=%b c=%b amt=%0d cr=%0d rej=%b busy=%b vend=%0d, required %05h (got %05h)",
               tag, act[19], act[18], act[17:14], act[13:10], act[9], act[8], act[7:0], v.exp, act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; coin = 2'b00; sel = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;

    //                r coin  s  cn da ca   d  ch amt   cr    rj bz vend
    vecs.push_back(mk(1, 2'b10, 1, 1, 1, 1,  0, 0, 4'd0, 4'd0, 0, 0, 8'd0)); // reset overrides
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 0,  0, 0, 4'd0, 4'd0, 0, 0, 8'd0));
    // exact price, no change
    vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  0, 0, 4'd0, 4'd1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  0, 0, 4'd0, 4'd3, 0, 0, 8'd0));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0,  1, 0, 4'd0, 4'd3, 0, 1, 8'd0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0,  1, 0, 4'd0, 4'd3, 0, 1, 8'd0));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1,  1, 0, 4'd0, 4'd3, 0, 1, 8'd0)); // chg_ack ignored
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0,  0, 0, 4'd0, 4'd0, 0, 0, 8'd1));
    // overpay, one unit of change
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  0, 0, 4'd0, 4'd2, 0, 0, 8'd1));
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  0, 0, 4'd0, 4'd4, 0, 0, 8'd1));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0,  1, 0, 4'd0, 4'd4, 0, 1, 8'd1));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0,  0, 1, 4'd1, 4'd1, 0, 1, 8'd2));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0,  0, 1, 4'd1, 4'd1, 0, 1, 8'd2));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1,  0, 0, 4'd0, 4'd0, 0, 0, 8'd2));
    // credit ceiling
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  0, 0, 4'd0, 4'd2, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  0, 0, 4'd0, 4'd4, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  0, 0, 4'd0, 4'd5, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  0, 0, 4'd0, 4'd5, 1, 0, 8'd2));
    vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  0, 0, 4'd0, 4'd6, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  0, 0, 4'd0, 4'd6, 1, 0, 8'd2));
    vecs.push_back(mk(0, 2'b11, 0, 1, 0, 0,  0, 1, 4'd6, 4'd6, 0, 1, 8'd2)); // 11 is no coin
    vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  0, 1, 4'd6, 4'd6, 1, 1, 8'd2));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1,  0, 0, 4'd0, 4'd0, 0, 0, 8'd2));
    // short sel ignored, then sel+cancel: cancel wins
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  0, 0, 4'd0, 4'd2, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b00, 1, 0, 0, 0,  0, 0, 4'd0, 4'd2, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  0, 0, 4'd0, 4'd4, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b00, 1, 1, 0, 0,  0, 1, 4'd4, 4'd4, 0, 1, 8'd2));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1,  0, 0, 4'd0, 4'd0, 0, 0, 8'd2));
    // acks and sel/cancel in IDLE are ignored
    vecs.push_back(mk(0, 2'b00, 1, 1, 1, 1,  0, 0, 4'd0, 4'd0, 0, 0, 8'd2));
    // cancel with a coin in the same cycle refunds the coin too
    vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  0, 0, 4'd0, 4'd1, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b10, 0, 1, 0, 0,  0, 1, 4'd3, 4'd3, 0, 1, 8'd2));
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1,  0, 0, 4'd0, 4'd0, 0, 0, 8'd2));
    // sel with a coin in the same cycle adds the coin
    vecs.push_back(mk(0, 2'b10, 0, 0, 0, 0,  0, 0, 4'd0, 4'd2, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b01, 0, 0, 0, 0,  0, 0, 4'd0, 4'd3, 0, 0, 8'd2));
    vecs.push_back(mk(0, 2'b10, 1, 0, 0, 0,  1, 0, 4'd0, 4'd5, 0, 1, 8'd2));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0,  0, 1, 4'd2, 4'd2, 0, 1, 8'd3));
    vecs.push_back(mk(0, 2'b00, 0, 0, 1, 0,  0, 1, 4'd2, 4'd2, 0, 1, 8'd3)); // disp_ack ignored
    vecs.push_back(mk(0, 2'b00, 0, 0, 0, 1,  0, 0, 4'd0, 4'd0, 0, 0, 8'd3));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("tbl[%0d]", i));

    // Timeout: one unit inserted, refund after exactly 20 idle cycles in CREDIT.
    step(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 4'd0, 4'd1, 0, 0, 8'd3), "to_coin");
    for (int i = 1; i < 20; i++)
      step(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0, 4'd1, 0, 0, 8'd3), $sformatf("to_idle%0d", i));
    step(mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 4'd1, 4'd1, 0, 1, 8'd3), "to_expire");
    step(mk(0, 2'b01, 0, 0, 0, 0, 0, 1, 4'd1, 4'd1, 1, 1, 8'd3), "to_coin_rej");
    step(mk(0, 2'b00, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 8'd3), "to_ack");

    // Reset while dispensing drops the request; a late ack does nothing.
    step(mk(0, 2'b10, 0, 0, 0, 0, 0, 0, 4'd0, 4'd2, 0, 0, 8'd3), "rs_coin1");
    step(mk(0, 2'b10, 0, 0, 0, 0, 0, 0, 4'd0, 4'd4, 0, 0, 8'd3), "rs_coin2");
    step(mk(0, 2'b00, 1, 0, 0, 0, 1, 0, 4'd0, 4'd4, 0, 1, 8'd3), "rs_sel");
    step(mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 8'd0), "rs_reset");
    step(mk(0, 2'b00, 0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 8'd0), "rs_late_ack");
    step(mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 4'd0, 4'd1, 0, 0, 8'd0), "rs_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
